// File: rtl/lut_loader.sv
// Run-time loadable lookup table for the normalization path.
// A valid/ready stream fills the table from address 0 upward. The lookup
// side is a registered, enable-gated read with 1-cycle latency.
module lut_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter string       TYPE       = "DISTRIBUTED"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned ROM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_done;
    logic                  r_ready;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_beat;

    // r_ready is high exactly in LOAD; a load_start in the same cycle drops the beat
    assign w_beat = r_ready & wr_valid & ~load_start;

    // Load sequencer: state, write pointer, word count and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        r_ptr   <= '0;
                        r_count <= '0;
                    end else if (wr_valid) begin
                        r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                        r_count <= r_count + CNT_WIDTH'(1);
                        if (r_ptr == LAST_ADDR) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Table storage; the branch only selects the ram_style mapping hint
    generate
        if (TYPE == "BLOCK") begin : g_table
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [ROM_DEPTH];

            // Stream write port
            always_ff @(posedge clk) begin
                if (w_beat) r_mem[r_ptr] <= wr_data;
            end

            // Registered lookup; same-cycle write to the read address returns old data
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       r_data <= '0;
                else if (enable) r_data <= r_mem[address];
            end
        end else begin : g_table
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [ROM_DEPTH];

            // Stream write port
            always_ff @(posedge clk) begin
                if (w_beat) r_mem[r_ptr] <= wr_data;
            end

            // Registered lookup; same-cycle write to the read address returns old data
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       r_data <= '0;
                else if (enable) r_data <= r_mem[address];
            end
        end
    endgenerate

    assign wr_ready   = r_ready;
    assign load_busy  = r_busy;
    assign load_done  = r_done;
    assign word_count = r_count;
    assign data_out   = r_data;

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: a small reference model of the table and
// write pointer feeds a scoreboard queue of expected lookup results.
module tb_lut_loader;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          load_busy;
    logic          load_done;
    logic [AW:0]   word_count;
    logic [AW-1:0] address;
    logic          enable;
    logic [DW-1:0] data_out;

    lut_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TYPE("DISTRIBUTED")) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .word_count (word_count),
        .address    (address),
        .enable     (enable),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] model [DEPTH];
    logic [AW-1:0] tb_ptr = '0;
    bit            tb_loading = 1'b0;
    logic [DW-1:0] last_exp = '0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict table/read effect, compare data_out after the edge
    task automatic step(input bit start, input bit valid, input logic [DW-1:0] data,
                        input bit en, input logic [AW-1:0] addr);
        logic [DW-1:0] e;
        load_start = start;
        wr_valid   = valid;
        wr_data    = data;
        enable     = en;
        address    = addr;
        exp_q.push_back(en ? model[addr] : last_exp);
        if (start) begin
            tb_loading = 1'b1;
            tb_ptr     = '0;
        end else if (valid && tb_loading) begin
            model[tb_ptr] = data;
            tb_ptr        = tb_ptr + AW'(1);
            if (tb_ptr == '0) tb_loading = 1'b0;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e));
            last_exp = e;
        end
        load_start = 1'b0;
        wr_valid   = 1'b0;
        enable     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        enable = 1'b0; address = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_busy",  32'(load_busy), 32'd0);
        check("rst_done",  32'(load_done), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_data",  32'(data_out), 32'd0);
        reset = 1'b0;

        // Full back-to-back load of 0x1000+i
        step(1, 0, '0, 0, '0);
        check("load_ready", 32'(wr_ready), 32'd1);
        check("load_busy",  32'(load_busy), 32'd1);
        check("load_count0", 32'(word_count), 32'd0);
        for (int i = 0; i < 64; i++) begin
            check("beat_ready", 32'(wr_ready), 32'd1);
            step(0, 1, DW'(16'h1000 + i), 0, '0);
            if (i == 62) begin
                check("count63", 32'(word_count), 32'd63);
                check("done_early", 32'(load_done), 32'd0);
            end
        end
        check("done_set",   32'(load_done), 32'd1);
        check("count64",    32'(word_count), 32'd64);
        check("ready_off",  32'(wr_ready), 32'd0);
        check("busy_off",   32'(load_busy), 32'd0);
        // Writes in DONE are ignored
        step(0, 1, 16'hBEEF, 0, '0);
        check("done_hold",  32'(load_done), 32'd1);
        check("done_count", 32'(word_count), 32'd64);

        // Lookups: 5, 63, then hold with enable low
        step(0, 0, '0, 1, 6'd5);
        step(0, 0, '0, 1, 6'd63);
        step(0, 0, '0, 0, 6'd5);
        step(0, 0, '0, 1, 6'd0);

        // Gapped stream: 10 valid beats over 20 cycles
        step(1, 0, '0, 0, '0);
        check("reload_done", 32'(load_done), 32'd0);
        check("reload_count", 32'(word_count), 32'd0);
        for (int c = 0; c < 20; c++)
            step(0, (c % 2) == 0, DW'(16'h2000 + c / 2), 0, '0);
        check("gap_count", 32'(word_count), 32'd10);
        check("gap_done",  32'(load_done), 32'd0);
        for (int k = 10; k < 19; k++)
            step(0, 1, DW'(16'h2000 + k), 0, '0);
        check("count19", 32'(word_count), 32'd19);
        // Restart on the 20th beat: that beat is dropped
        step(1, 1, 16'h2013, 0, '0);
        check("restart_count", 32'(word_count), 32'd0);
        check("restart_ready", 32'(wr_ready), 32'd1);
        step(0, 1, 16'h3000, 0, '0);
        check("after_restart_count", 32'(word_count), 32'd1);
        step(0, 0, '0, 1, 6'd0);
        step(0, 0, '0, 1, 6'd19);
        step(0, 0, '0, 1, 6'd18);

        // Read/write collision at address 3: old 0xAAAA, new 0x5555
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h4000 + i), 0, '0);
        step(0, 1, 16'hAAAA, 0, '0);
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h4100 + i), 0, '0);
        step(0, 1, 16'h5555, 1, 6'd3);
        check("collision_old", 32'(data_out), 32'hAAAA);
        step(0, 0, '0, 1, 6'd3);
        check("collision_new", 32'(data_out), 32'h5555);

        // Reset mid-load after 30 beats
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 30; i++) step(0, 1, DW'(16'h6000 + i), 1, 6'd40);
        check("pre_rst_count", 32'(word_count), 32'd30);
        #2 reset = 1'b1;
        #1;
        check("arst_done",  32'(load_done), 32'd0);
        check("arst_data",  32'(data_out), 32'd0);
        check("arst_ready", 32'(wr_ready), 32'd0);
        check("arst_busy",  32'(load_busy), 32'd0);
        check("arst_count", 32'(word_count), 32'd0);
        #1 reset = 1'b0;
        tb_loading = 1'b0;
        tb_ptr     = '0;
        last_exp   = '0;
        for (int i = 0; i < 3; i++) step(0, 1, 16'hDEAD, 0, '0);
        check("idle_count", 32'(word_count), 32'd0);
        check("idle_ready", 32'(wr_ready), 32'd0);
        step(0, 0, '0, 1, 6'd0);
        step(0, 0, '0, 1, 6'd29);
        step(0, 0, '0, 1, 6'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Writable lookup table for the normalization path. Software/host streams the table contents in at run time instead of preloading them from a file at elaboration.
- Write side: valid/ready word stream that fills the table sequentially from address 0 to ROM_DEPTH-1, with a load_done indication.
- Read side: keeps the existing lookup contract (registered, 1-cycle latency, enable-gated), so downstream normalization logic consumes it unchanged.

Parameters:
- DATA_WIDTH, 16, width of each table word.
- ADDR_WIDTH, 6, address width; ROM_DEPTH = 1 << ADDR_WIDTH entries.
- TYPE, "DISTRIBUTED", ram_style attribute applied to the table array.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins (or restarts) a table load at address 0.
- wr_data  input  DATA_WIDTH  stream word to write.
- wr_valid  input  1  wr_data is valid.
- wr_ready  output  1  block accepts a word this cycle.
- load_busy  output  1  high while in LOAD.
- load_done  output  1  high once all ROM_DEPTH words of the current load have been written.
- word_count  output  ADDR_WIDTH+1  words accepted in the current load, 0..ROM_DEPTH.
- address  input  ADDR_WIDTH  lookup address.
- enable  input  1  lookup enable.
- data_out  output  DATA_WIDTH  registered lookup result.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, write pointer=0, word_count=0.
  - load_done=0, load_busy=0, wr_ready=0, data_out=0.
  - Table contents are not cleared; they are undefined until the first completed load.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: wr_ready=0. load_start moves to LOAD with pointer=0, word_count=0, load_done=0.
  - LOAD: wr_ready=1, load_busy=1. A beat is a cycle with wr_valid and wr_ready high. Each beat writes mem[pointer]=wr_data, then increments pointer and word_count.
  - LOAD to DONE: the beat at pointer=ROM_DEPTH-1 moves to DONE. On that same edge load_done=1, word_count=ROM_DEPTH, pointer wraps to 0. wr_ready is 0 from the next cycle.
  - DONE: load_done=1 and holds. Any wr_valid is ignored and nothing is written. load_start returns to LOAD and clears load_done and word_count.
- Outputs wr_ready and load_busy are decoded from registered state only; they have no combinational dependence on inputs.
- load_start asserted in LOAD: restarts the load. Pointer=0, word_count=0. Any beat in that same cycle is discarded, not written. Previously written entries keep their values until overwritten.
- Gaps (wr_valid low) in LOAD stall the load indefinitely; there is no timeout.
- Read path, all states:
  - enable=1: data_out <= mem[address] at the next edge (1-cycle latency).
  - enable=0: data_out holds its value.
- Read/write collision: a read and a write to the same address in the same cycle return the OLD contents (read-before-write). The new value is visible from the next read.
- Reads during LOAD are legal and return whatever is stored. Consumers gate lookups on load_done.
- Reset asserted mid-load: the FSM aborts to IDLE immediately. Partially written entries remain; load_done=0.

Test Plan:
- Reset, then pulse load_start and stream 64 words 0x1000+i back-to-back (ADDR_WIDTH=6) -> wr_ready=1 on cycles 1..64; load_done rises on the edge of beat 64; word_count=64; wr_ready=0 afterwards.
- After the load, enable=1 with address=5, then address=63 -> data_out=0x1005, then 0x103F, each 1 cycle after its address; enable=0 -> data_out holds 0x103F.
- Stream with wr_valid toggling every other cycle -> only valid cycles count; after 10 valid beats word_count=10 and load_done=0.
- load_start asserted alongside the 20th beat -> that beat is not written; word_count=0; the next beat writes address 0.
- Same-cycle read and write of address 3 (old value 0xAAAA, new 0x5555) -> data_out=0xAAAA; a re-read the next cycle gives 0x5555.
- Assert reset after 30 beats -> state IDLE, load_done=0, data_out=0, wr_ready=0 asynchronously; wr_valid is ignored until load_start.
